mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit that sequences the shared ARM datapath (single memory, one ALU, register file, PC and IR) of the multicycle variant of `data_proc_top`. It decodes the latched instruction fields and steps through a per-instruction state sequence. It drives every mux select and write strobe. It owns the NZCV flag register and condition-code evaluation, so the datapath stays purely structural.

## Interface
Parameters:
- none (encodings live in the package)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- Instr  in  20  IR bits [31:12]: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
- ALUFlags  in  4  NZCV from ALU, current cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register load
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  1  0 = RD1 reg, 1 = PC
- ALUSrcB  out  2  00 RD2 reg, 01 ExtImm, 10 constant 4
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- ImmSrc  out  2  equals op
- RegSrc  out  2  [0] = (op==10), [1] = (op==01)
- RegWrite  out  1  register file write strobe
- State  out  4  current state encoding, for debug and bench

## Operation
States and their decoded controls (fields not listed are 0):
- FETCH(0): AdrSrc 0, IRWrite, ALUSrcA 1, ALUSrcB 10, ResultSrc 10, NextPC. Goes to DECODE.
- DECODE(1): ALUSrcA 1, ALUSrcB 10, ResultSrc 10. Latches CondEx into condex_q. Next state by op:
  - op 01, funct[0]=1 → MEMADR, then MEMRD
  - op 01, funct[0]=0 → MEMADR, then MEMWR
  - op 00, funct[5]=0 → EXECR
  - op 00, funct[5]=1 → EXECI
  - op 10 → BRANCH
  - op 11 → FETCH (no-op)
- MEMADR(2): ALUSrcB 01 (address computation).
- MEMRD(3): AdrSrc 1 → MEMWB.
- MEMWB(4): ResultSrc 01, RegW → FETCH.
- MEMWR(5): AdrSrc 1, MemW → FETCH.
- EXECR(6): ALUSrcB 00, ALUOp → ALUWB.
- EXECI(7): ALUSrcB 01, ALUOp → ALUWB.
- ALUWB(8): ResultSrc 00, RegW → FETCH.
- BRANCH(9): ALUSrcB 01, ResultSrc 10, Branch → FETCH.
- Encodings 10–15 are illegal and go to FETCH.

ALU decode:
- ALUOp=0 → ADD.
- ALUOp=1 → cmd funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
- Other cmds → ADD with NoWrite (RegW suppressed).

Condition logic:
- Codes 0000–1110 use standard ARM meaning against the flag register; 1110 is always true.
- Code 1111 → CondEx 0.

Gating:
- RegWrite = RegW & condex_q & ~NoWrite
- MemWrite = MemW & condex_q
- PCS = (Rd==15 & RegW) | Branch
- PCWrite = NextPC | (PCS & condex_q)

Flags:
- FlagW[1] = S (NZ); FlagW[0] = S & cmd ∈ {ADD, SUB} (CV).
- In EXECR/EXECI, on the clock edge: NZ ← ALUFlags[3:2] if FlagW[1] & condex_q; CV ← ALUFlags[1:0] if FlagW[0] & condex_q.

## Timing
Latency in cycles, FETCH to next FETCH:
- LDR 5
- STR 4
- DP 4
- B 3
- op 11: 2

Other rules:
- All outputs are combinational from State and the registered condex_q and flags. There is no output latency beyond the state register.
- Reset, asynchronous:
  - State ← FETCH; flags ← 0000; condex_q ← 0.
  - While reset=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. Mux selects show FETCH values.
- Reset asserted mid-instruction aborts it. No write strobe fires in the reset cycle. The first FETCH is the rising edge after deassertion.
- Instr must be stable from DECODE to the end of the instruction (IRWrite only in FETCH).
- A flag update and its use by the next instruction's DECODE never coincide: the update is always at least 2 cycles earlier.

## Configuration
- `MC_CTRL_CMP_EN` defined: cmd 1010 (CMP) decodes as SUB with NoWrite=1. CV and NZ flags update when S=1.
- Without it: cmd 1010 takes the unsupported-cmd path (ADD, NoWrite). FlagW[0]=0, so only NZ updates.

## Structure
- Package `mc_ctrl_pkg`:
  - state enum `mc_state_t` (4-bit)
  - ALUControl encodings
  - cmd constants (CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP)
  - ResultSrc/ALUSrcB encodings
- Sub-module `mc_cond_logic`: flag register, condition evaluation, condex_q, FlagW gating.
- Top: FSM, main decoder and ALU decoder.

## Test plan
- Reset held 3 cycles, then released → State=0 and all strobes 0 during reset; cycle 1 after release: IRWrite=1, PCWrite=1, AdrSrc=0.
- Instr=0xE5912 (LDR, Rd=2), ALUFlags=0 → states 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01.
- SUBS: Instr=0xE0512, ALUFlags=0110 in EXECR → ALUControl=01; flags become 0110. Following EQ-cond ADD (cond 0000) → RegWrite=1 in ALUWB.
- Instr with cond=0001 (NE) after Z=1 → sequence runs, RegWrite and MemWrite never assert.
- B: Instr=0xEA000 → states 0,1,9,0; PCWrite=1 in BRANCH with ResultSrc=10. Same with cond 1111 → PCWrite=0 in BRANCH.
- CMP: Instr=0xE1530, ALUFlags=1000 → with `MC_CTRL_CMP_EN`: ALUControl=01, RegWrite=0, flags=1000. Without it: ALUControl=00, RegWrite=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, ALU, command and mux-select encodings plus ARM condition evaluation
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } mc_state_t;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  // flags are {N,Z,C,V}; each odd code is the negation of the even code below it, so 1111 is never
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
    logic base;
    case (cond[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] & ~f[2];
      3'd5: base = f[3] == f[0];
      3'd6: base = ~f[2] & (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction
endpackage

// File: rtl/mc_cond_logic.sv
// mc_cond_logic: NZCV flag register, condition check and per-instruction condex_q latch
module mc_cond_logic
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       latch,
  output logic       condex_q
);
  logic [3:0] flags;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flags    <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      if (latch) condex_q <= cond_holds(cond, flags);
      if (flag_w[1] && condex_q) flags[3:2] <= alu_flags[3:2];
      if (flag_w[0] && condex_q) flags[1:0] <= alu_flags[1:0];
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM control FSM with main and ALU decoders
// Define MC_CTRL_CMP_EN to decode CMP as a flag-setting SUB without register write.
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [3:0]  State
);
  mc_state_t st, nxt;
  logic [1:0] op, flag_w;
  logic [5:0] funct;
  logic [3:0] cmd, rd;
  logic unused_rn, next_pc, decode, reg_w, mem_w, branch, alu_op;
  logic is_add, is_sub, is_and, is_orr, no_write, pcs, condex_q;
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign cmd       = funct[4:1];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= S_FETCH;
    else st <= nxt;
  always_comb begin
    nxt = S_FETCH;
    case (st)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: nxt = op == 2'b01 ? S_MEMADR :
                      op == 2'b00 ? (funct[5] ? S_EXECI : S_EXECR) :
                      op == 2'b10 ? S_BRANCH : S_FETCH;
      S_MEMADR: nxt = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = S_MEMWB;
      S_EXECR:  nxt = S_ALUWB;
      S_EXECI:  nxt = S_ALUWB;
      default:  nxt = S_FETCH;
    endcase
  end
  assign next_pc = st == S_FETCH;
  assign decode  = st == S_DECODE;
  assign reg_w   = st == S_MEMWB || st == S_ALUWB;
  assign mem_w   = st == S_MEMWR;
  assign branch  = st == S_BRANCH;
  assign alu_op  = st == S_EXECR || st == S_EXECI;
  assign is_add  = cmd == CMD_ADD;
`ifdef MC_CTRL_CMP_EN
  assign is_sub  = cmd == CMD_SUB || cmd == CMD_CMP;
`else
  assign is_sub  = cmd == CMD_SUB;
`endif
  assign is_and  = cmd == CMD_AND;
  assign is_orr  = cmd == CMD_ORR;
  // NoWrite is decoded from the instruction so it still holds in ALUWB, after ALUOp has dropped
  assign no_write   = op == 2'b00 && !(cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR});
  assign ALUControl = !alu_op ? ALU_ADD : is_sub ? ALU_SUB : is_and ? ALU_AND : is_orr ? ALU_ORR : ALU_ADD;
  assign flag_w     = {alu_op & funct[0], alu_op & funct[0] & (is_add | is_sub)};
  mc_cond_logic u_cond (
    .clk       (clk),
    .rst       (reset),
    .cond      (Instr[19:16]),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .latch     (decode),
    .condex_q  (condex_q)
  );
  assign pcs        = (rd == 4'hF && reg_w) || branch;
  assign PCWrite    = !reset && (next_pc || (pcs && condex_q));
  assign IRWrite    = !reset && next_pc;
  assign MemWrite   = !reset && mem_w && condex_q;
  assign RegWrite   = !reset && reg_w && condex_q && !no_write;
  assign AdrSrc     = st == S_MEMRD || st == S_MEMWR;
  assign ResultSrc  = (next_pc || decode || branch) ? RES_ALURESULT : st == S_MEMWB ? RES_DATA : RES_ALUOUT;
  assign ALUSrcA    = next_pc || decode;
  assign ALUSrcB    = (next_pc || decode) ? SRCB_FOUR : (st == S_MEMADR || st == S_EXECI || branch) ? SRCB_IMM : SRCB_RD2;
  assign ImmSrc     = op;
  assign RegSrc     = {op == 2'b01, op == 2'b10};
  assign State      = st;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed instruction sequences checked with immediate assertions
module tb_mc_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] Instr = 20'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  State;
  int checks = 0;
  int errors = 0;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .State      (State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] st, input logic rw, input logic mw, input logic pw);
    chk({tag, ".state"}, State, st);
    chk({tag, ".regwrite"}, {3'b0, RegWrite}, {3'b0, rw});
    chk({tag, ".memwrite"}, {3'b0, MemWrite}, {3'b0, mw});
    chk({tag, ".pcwrite"}, {3'b0, PCWrite}, {3'b0, pw});
    @(negedge clk);
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.state", State, 4'd0);
    chk("rst.pcwrite", {3'b0, PCWrite}, 4'd0);
    chk("rst.irwrite", {3'b0, IRWrite}, 4'd0);
    chk("rst.memwrite", {3'b0, MemWrite}, 4'd0);
    chk("rst.regwrite", {3'b0, RegWrite}, 4'd0);
    chk("rst.alusrcb", {2'b0, ALUSrcB}, 4'd2);
    chk("rst.resultsrc", {2'b0, ResultSrc}, 4'd2);
    Instr = 20'hE5912;
    reset = 1'b0;
    #1;
    chk("rel.irwrite", {3'b0, IRWrite}, 4'd1);
    chk("rel.pcwrite", {3'b0, PCWrite}, 4'd1);
    chk("rel.adrsrc", {3'b0, AdrSrc}, 4'd0);
    // LDR r2
    step("ldr.f", 4'd0, 0, 0, 1);
    chk("ldr.d.regsrc", {2'b0, RegSrc}, 4'd2);
    step("ldr.d", 4'd1, 0, 0, 0);
    chk("ldr.ma.alusrcb", {2'b0, ALUSrcB}, 4'd1);
    step("ldr.ma", 4'd2, 0, 0, 0);
    chk("ldr.mr.adrsrc", {3'b0, AdrSrc}, 4'd1);
    step("ldr.mr", 4'd3, 0, 0, 0);
    chk("ldr.wb.resultsrc", {2'b0, ResultSrc}, 4'd1);
    step("ldr.wb", 4'd4, 1, 0, 0);
    // SUBS r2 sets Z and C
    Instr = 20'hE0512;
    ALUFlags = 4'b0110;
    step("subs.f", 4'd0, 0, 0, 1);
    step("subs.d", 4'd1, 0, 0, 0);
    chk("subs.ex.aluctl", {2'b0, ALUControl}, 4'd1);
    chk("subs.ex.alusrcb", {2'b0, ALUSrcB}, 4'd0);
    step("subs.ex", 4'd6, 0, 0, 0);
    chk("subs.flags", dut.u_cond.flags, 4'b0110);
    step("subs.wb", 4'd8, 1, 0, 0);
    ALUFlags = 4'b0000;
    // ADDEQ r3 with Z=1
    Instr = 20'h00803;
    step("addeq.f", 4'd0, 0, 0, 1);
    step("addeq.d", 4'd1, 0, 0, 0);
    chk("addeq.ex.aluctl", {2'b0, ALUControl}, 4'd0);
    step("addeq.ex", 4'd6, 0, 0, 0);
    step("addeq.wb", 4'd8, 1, 0, 0);
    // STRNE and ADDNE with Z=1 never write
    Instr = 20'h15802;
    step("strne.f", 4'd0, 0, 0, 1);
    step("strne.d", 4'd1, 0, 0, 0);
    step("strne.ma", 4'd2, 0, 0, 0);
    step("strne.mw", 4'd5, 0, 0, 0);
    Instr = 20'h10803;
    step("addne.f", 4'd0, 0, 0, 1);
    step("addne.d", 4'd1, 0, 0, 0);
    step("addne.ex", 4'd6, 0, 0, 0);
    step("addne.wb", 4'd8, 0, 0, 0);
    // STR always
    Instr = 20'hE5802;
    step("str.f", 4'd0, 0, 0, 1);
    step("str.d", 4'd1, 0, 0, 0);
    step("str.ma", 4'd2, 0, 0, 0);
    chk("str.mw.adrsrc", {3'b0, AdrSrc}, 4'd1);
    step("str.mw", 4'd5, 0, 1, 0);
    // ORR immediate
    Instr = 20'hE3804;
    step("orri.f", 4'd0, 0, 0, 1);
    step("orri.d", 4'd1, 0, 0, 0);
    chk("orri.ex.aluctl", {2'b0, ALUControl}, 4'd3);
    chk("orri.ex.alusrcb", {2'b0, ALUSrcB}, 4'd1);
    step("orri.ex", 4'd7, 0, 0, 0);
    step("orri.wb", 4'd8, 1, 0, 0);
    // ADD with Rd=15 loads the PC
    Instr = 20'hE080F;
    step("addpc.f", 4'd0, 0, 0, 1);
    step("addpc.d", 4'd1, 0, 0, 0);
    step("addpc.ex", 4'd6, 0, 0, 0);
    step("addpc.wb", 4'd8, 1, 0, 1);
    // B always, then B with cond 1111
    Instr = 20'hEA000;
    step("b.f", 4'd0, 0, 0, 1);
    chk("b.d.immsrc", {2'b0, ImmSrc}, 4'd2);
    step("b.d", 4'd1, 0, 0, 0);
    chk("b.br.resultsrc", {2'b0, ResultSrc}, 4'd2);
    step("b.br", 4'd9, 0, 0, 1);
    Instr = 20'hFA000;
    step("bnv.f", 4'd0, 0, 0, 1);
    step("bnv.d", 4'd1, 0, 0, 0);
    step("bnv.br", 4'd9, 0, 0, 0);
    // op 11 is a two-cycle no-op
    Instr = 20'hEC000;
    step("nop.f", 4'd0, 0, 0, 1);
    step("nop.d", 4'd1, 0, 0, 0);
    // CMP r3 with N set by the ALU
    Instr = 20'hE1530;
    ALUFlags = 4'b1000;
    step("cmp.f", 4'd0, 0, 0, 1);
    step("cmp.d", 4'd1, 0, 0, 0);
`ifdef MC_CTRL_CMP_EN
    chk("cmp.ex.aluctl", {2'b0, ALUControl}, 4'd1);
    step("cmp.ex", 4'd6, 0, 0, 0);
    chk("cmp.flags", dut.u_cond.flags, 4'b1000);
`else
    chk("cmp.ex.aluctl", {2'b0, ALUControl}, 4'd0);
    step("cmp.ex", 4'd6, 0, 0, 0);
    chk("cmp.flags", dut.u_cond.flags, 4'b1010);
`endif
    step("cmp.wb", 4'd8, 0, 0, 0);
    ALUFlags = 4'b0000;
    // reset mid-LDR, in the writeback cycle
    Instr = 20'hE5912;
    step("ldr2.f", 4'd0, 0, 0, 1);
    step("ldr2.d", 4'd1, 0, 0, 0);
    step("ldr2.ma", 4'd2, 0, 0, 0);
    step("ldr2.mr", 4'd3, 0, 0, 0);
    chk("ldr2.wb.regwrite", {3'b0, RegWrite}, 4'd1);
    reset = 1'b1;
    #1;
    chk("abort.state", State, 4'd0);
    chk("abort.regwrite", {3'b0, RegWrite}, 4'd0);
    chk("abort.irwrite", {3'b0, IRWrite}, 4'd0);
    chk("abort.flags", dut.u_cond.flags, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel2.state", State, 4'd0);
    chk("rel2.irwrite", {3'b0, IRWrite}, 4'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
